// File: rtl/insn_decode_stage_pkg.sv
// Shared constants for the instruction decode stage: class indices, default widths
// and operand field positions used by both the control logic and its consumers.
package insn_decode_stage_pkg;

    localparam int unsigned CLASS_IMMEDIATE   = 0;
    localparam int unsigned CLASS_CALCULATION = 1;
    localparam int unsigned CLASS_COPY        = 2;
    localparam int unsigned CLASS_CONDITION   = 3;

    localparam int unsigned DEFAULT_OPCODE_W   = 8;
    localparam int unsigned DEFAULT_CLASS_BITS = 2;
    localparam int unsigned DEFAULT_FIELD_W    = 3;
    localparam int unsigned DEFAULT_CNT_W      = 16;

    localparam int unsigned DST_LSB = 0;

    // The source field sits directly above the destination field.
    function automatic int unsigned src_lsb(input int unsigned field_w);
        return DST_LSB + field_w;
    endfunction

endpackage

// File: rtl/insn_decode_stage_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign value = count_q;

endmodule

// File: rtl/insn_decode_stage.sv
// One-deep decode pipeline stage: registers a one-hot class and operand fields from the
// fetched opcode behind a valid/ready handshake, and counts retired instructions per class.
module insn_decode_stage
    import insn_decode_stage_pkg::*;
#(
    parameter int unsigned OPCODE_W   = DEFAULT_OPCODE_W,
    parameter int unsigned CLASS_BITS = DEFAULT_CLASS_BITS,
    parameter int unsigned FIELD_W    = DEFAULT_FIELD_W,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OPCODE_W-1:0]          in_opcode,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [(2**CLASS_BITS)-1:0]   out_class,
    output logic [OPCODE_W-1:0]          out_opcode,
    output logic [OPCODE_W-CLASS_BITS-1:0] out_imm,
    output logic [FIELD_W-1:0]           out_src,
    output logic [FIELD_W-1:0]           out_dst,
    input  logic [CLASS_BITS-1:0]        cnt_sel,
    output logic [CNT_W-1:0]             cnt_value,
    input  logic                         cnt_clr
);

    localparam int unsigned NUM_CLASSES = 2 ** CLASS_BITS;
    localparam int unsigned IMM_W       = OPCODE_W - CLASS_BITS;
    localparam int unsigned SRC_LSB     = src_lsb(FIELD_W);

    if (CLASS_BITS + 2 * FIELD_W > OPCODE_W) begin : g_width_check
        $error("insn_decode_stage: class and register fields do not fit in the opcode");
    end

    logic                    valid_q;
    logic [NUM_CLASSES-1:0]  class_q;
    logic [OPCODE_W-1:0]     opcode_q;
    logic [IMM_W-1:0]        imm_q;
    logic [FIELD_W-1:0]      src_q;
    logic [FIELD_W-1:0]      dst_q;

    logic                    accept;
    logic                    transfer;
    logic [CLASS_BITS-1:0]   in_class_idx;
    logic [NUM_CLASSES-1:0]  cnt_inc;
    logic [CNT_W-1:0]        cnt_values [NUM_CLASSES];

    assign in_ready     = !flush && (!valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    // Flush suppresses the transfer so a dropped instruction is never counted.
    assign transfer     = valid_q && out_ready && !flush;
    assign in_class_idx = in_opcode[OPCODE_W-1 -: CLASS_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            class_q  <= '0;
            opcode_q <= '0;
            imm_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            class_q  <= NUM_CLASSES'(1) << in_class_idx;
            opcode_q <= in_opcode;
            imm_q    <= in_opcode[IMM_W-1:0];
            src_q    <= in_opcode[SRC_LSB +: FIELD_W];
            dst_q    <= in_opcode[DST_LSB +: FIELD_W];
        end else if (transfer || flush) begin
            valid_q  <= 1'b0;
        end
    end

    assign cnt_inc = class_q & {NUM_CLASSES{transfer}};

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (cnt_clr),
            .inc   (cnt_inc[k]),
            .value (cnt_values[k])
        );
    end

    assign cnt_value  = cnt_values[cnt_sel];

    assign out_valid  = valid_q;
    assign out_class  = class_q;
    assign out_opcode = opcode_q;
    assign out_imm    = imm_q;
    assign out_src    = src_q;
    assign out_dst    = dst_q;

endmodule

// File: tb/tb_insn_decode_stage.sv
// Directed self-checking bench for insn_decode_stage (default widths, 4-bit counters).
module tb_insn_decode_stage;
    import insn_decode_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_opcode = 8'h00;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_class;
    logic [7:0] out_opcode;
    logic [5:0] out_imm;
    logic [2:0] out_src;
    logic [2:0] out_dst;
    logic [1:0] cnt_sel = 2'd0;
    logic [3:0] cnt_value;
    logic       cnt_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    insn_decode_stage #(
        .OPCODE_W   (8),
        .CLASS_BITS (2),
        .FIELD_W    (3),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_opcode (out_opcode),
        .out_imm    (out_imm),
        .out_src    (out_src),
        .out_dst    (out_dst),
        .cnt_sel    (cnt_sel),
        .cnt_value  (cnt_value),
        .cnt_clr    (cnt_clr)
    );

    typedef struct {
        logic [7:0] opcode;
        logic [3:0] cls;
        logic [5:0] imm;
        logic [2:0] src;
        logic [2:0] dst;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input int idx, input logic [3:0] exp, input string name);
        cnt_sel = 2'(idx);
        #1;
        check(name, 32'(cnt_value), 32'(exp));
    endtask

    vec_t vecs [4];
    logic [7:0] stream [8];

    initial begin
        vecs[0] = '{opcode: 8'h00, cls: 4'b0001, imm: 6'h00, src: 3'd0, dst: 3'd0};
        vecs[1] = '{opcode: 8'h44, cls: 4'b0010, imm: 6'h04, src: 3'd0, dst: 3'd4};
        vecs[2] = '{opcode: 8'h8A, cls: 4'b0100, imm: 6'h0A, src: 3'd1, dst: 3'd2};
        vecs[3] = '{opcode: 8'hC3, cls: 4'b1000, imm: 6'h03, src: 3'd0, dst: 3'd3};
        stream  = '{8'h01, 8'h42, 8'h83, 8'hC4, 8'h15, 8'h56, 8'h97, 8'hD8};

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_class", 32'(out_class), 32'd0);
        check("reset out_opcode", 32'(out_opcode), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) check_cnt(k, 4'd0, "reset counter");

        // Class decode table, one cycle latency
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_opcode = vecs[i].opcode;
            #1;
            check("decode in_ready", 32'(in_ready), 32'd1);
            cyc();
            in_valid = 1'b0;
            #1;
            check("decode out_valid", 32'(out_valid), 32'd1);
            check("decode out_class", 32'(out_class), 32'(vecs[i].cls));
            check("decode out_opcode", 32'(out_opcode), 32'(vecs[i].opcode));
            check("decode out_imm", 32'(out_imm), 32'(vecs[i].imm));
            check("decode out_src", 32'(out_src), 32'(vecs[i].src));
            check("decode out_dst", 32'(out_dst), 32'(vecs[i].dst));
        end
        cyc();
        check("decode drained", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) check_cnt(k, 4'd1, "decode counter");
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        for (int k = 0; k < 4; k++) check_cnt(k, 4'd0, "clear counter");

        // Backpressure
        in_valid  = 1'b1;
        in_opcode = 8'h8A;
        cyc();
        out_ready = 1'b0;
        in_opcode = 8'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_opcode", 32'(out_opcode), 32'h8A);
            check("stall out_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("after stall out_opcode", 32'(out_opcode), 32'h44);
        check("after stall out_class", 32'(out_class), 32'b0010);
        check_cnt(CLASS_COPY, 4'd1, "after stall counter2");
        check_cnt(CLASS_CALCULATION, 4'd0, "after stall counter1");
        cyc();
        check("after stall drained", 32'(out_valid), 32'd0);
        check_cnt(CLASS_CALCULATION, 4'd1, "drain counter1");

        // Flush beats a simultaneous out_ready
        in_valid  = 1'b1;
        in_opcode = 8'hC3;
        out_ready = 1'b0;
        cyc();
        in_opcode = 8'h00;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush input refused", 32'(out_opcode), 32'hC3);
        check_cnt(CLASS_CONDITION, 4'd0, "flush counter3");

        // Saturation: 20 calculation opcodes on top of an existing count of 1
        in_valid  = 1'b1;
        in_opcode = 8'h44;
        for (int i = 0; i < 20; i++) cyc();
        in_valid = 1'b0;
        cyc();
        check_cnt(CLASS_CALCULATION, 4'd15, "saturate counter1");
        // Clear coincident with a transfer
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        check("clr transfer out_valid", 32'(out_valid), 32'd0);
        check_cnt(CLASS_CALCULATION, 4'd0, "clr beats inc");

        // Reset during a stall with a nonzero counter
        in_valid  = 1'b1;
        in_opcode = 8'h8A;
        cyc();
        in_opcode = 8'hC3;
        cyc();
        out_ready = 1'b0;
        cyc();
        check_cnt(CLASS_COPY, 4'd1, "pre-reset counter2");
        check("pre-reset out_opcode", 32'(out_opcode), 32'hC3);
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset out_class", 32'(out_class), 32'd0);
        check("mid reset out_opcode", 32'(out_opcode), 32'd0);
        check("mid reset out_imm", 32'(out_imm), 32'd0);
        check("mid reset out_src", 32'(out_src), 32'd0);
        check("mid reset out_dst", 32'(out_dst), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) check_cnt(k, 4'd0, "mid reset counter");

        // Throughput: eight back-to-back opcodes, no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_opcode = stream[i];
            #1;
            check("stream in_ready", 32'(in_ready), 32'd1);
            cyc();
            check("stream out_valid", 32'(out_valid), 32'd1);
            check("stream out_opcode", 32'(out_opcode), 32'(stream[i]));
        end
        in_valid = 1'b0;
        cyc();
        check("stream drained", 32'(out_valid), 32'd0);
        for (int k = 0; k < 4; k++) check_cnt(k, 4'd2, "stream counter");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
